truth_table_capture: RTL
========================

# truth_table_capture

Response-side companion to the exhaustive six-input stimulus used on the combinational lab devices. The block sweeps all 64 input vectors onto a device under test, waits a programmable settle time per vector, and samples the device's single output into a 64-bit truth-table register. At the end of the sweep it reports the ones-count and a pass/fail compare against an expected table, so a synthesized device can be characterised on-board without a simulator.

## Interface

- SETTLE, 2, extra hold cycles per vector before sampling; legal 0..15; each vector held SETTLE+1 cycles
- EXPECTED, 64'h0, expected truth table; bit i = required x for vector i

- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  sampled only in IDLE; high begins a sweep
- vec  out  6  applied vector {a,b,c,d,e,f}, a = vec[5], f = vec[0]
- x  in  1  DUT output, sampled synchronously
- busy  out  1  high while sweeping
- done  out  1  one-cycle pulse after vector 63 captured
- table  out  64  captured truth table, bit i = x sampled for vec = i
- ones  out  7  count of 1s captured in this sweep, 0..64
- pass  out  1  table == EXPECTED; valid from done, held until next start
- misr  out  16  serial signature (present only with MISR_EN)

## Operation

- Reset values: vec=0, busy=0, done=0, table=0, ones=0, pass=0, misr=0, state IDLE, settle counter=0.
- States: IDLE -> RUN on start; RUN -> FINISH after capture of vector 63; FINISH -> IDLE unconditionally (one cycle).
- IDLE + start: table, ones, pass cleared; misr loaded 16'hFFFF; vec=0; counter=0; busy=1.
- RUN, each edge: if counter == SETTLE, capture x into table[vec], ones += x, misr update, counter=0, then vec += 1 or, if vec == 63, enter FINISH; otherwise counter += 1.
- FINISH: busy=0, done=1, pass registered from the completed table; vec returns to 0 on entry to IDLE.
- start ignored in RUN and FINISH; start held high yields back-to-back sweeps, the new sweep accepted on the first IDLE cycle.
- No wrap of vec past 63; ones saturates naturally at 64 (7 bits, no overflow).
- reset in any state wins over all other activity: all outputs to reset values next edge, sweep abandoned, no done pulse.

## Timing

- Start accepted at edge E0; vec=0 and busy=1 visible after E0.
- Vector i held from E0 + i*(SETTLE+1) to E0 + (i+1)*(SETTLE+1); x sampled at the last edge of the hold.
- Final capture at E0 + 64*(SETTLE+1); done=1 and busy=0 for the following cycle; pass and table stable from that cycle.
- Earliest next accepted start: one cycle after done (IDLE).
- x must be stable SETTLE+1 cycles after vec changes; combinational DUT path counted in that budget.

## Configuration

- MISR_EN defined: 16-bit serial CRC signature built; per capture fb = misr[15] ^ x, misr <= {misr[14:0],1'b0} ^ (fb ? 16'h1021 : 16'h0); misr port present, valid from done, held until next start.
- MISR_EN undefined: no signature register, misr port absent; all other behaviour identical.

## Test plan

- SETTLE=2, x = &vec -> table = 64'h8000_0000_0000_0000, ones=1, done 193 cycles after start edge (192 + 1).
- x = vec[0], EXPECTED = 64'hAAAA_AAAA_AAAA_AAAA -> table matches, ones=32, pass=1.
- x tied 0, EXPECTED = 64'h1 -> table=0, ones=0, pass=0, done still pulses once.
- reset pulsed 50 cycles into a sweep -> next cycle busy=0, vec=0, table=0, no done; fresh start then completes normally.
- start held high, SETTLE=0 -> sweep 64 cycles, done, one IDLE cycle, second sweep starts; start during RUN/FINISH has no effect.
- MISR_EN, x = vec[0] -> misr equals bench model of CRC-16/0x1021 seed FFFF over 64 captured bits; without MISR_EN, build succeeds with port absent.

Source files
------------

// File: rtl/truth_table_capture.sv
// Sweeps all 64 six-input vectors onto a device, captures its output into a truth table,
// and reports ones-count and pass/fail against EXPECTED. Define MISR_EN to add a CRC-16 signature port.
module truth_table_capture #(
  parameter int          SETTLE   = 2,
  parameter logic [63:0] EXPECTED = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [5:0]  vec,
  input  logic        x,
  output logic        busy,
  output logic        done,
  output logic [63:0] truth_table,
  output logic [6:0]  ones,
  output logic        pass
`ifdef MISR_EN
  ,
  output logic [15:0] misr
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  localparam logic [3:0] SETTLE_CNT = 4'(SETTLE);

  state_t     state_reg;
  logic [3:0] counter_reg;

`ifdef MISR_EN
  logic misr_fb;
  assign misr_fb = misr[15] ^ x;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      counter_reg <= 4'd0;
      vec         <= 6'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= 64'h0;
      ones        <= 7'd0;
      pass        <= 1'b0;
`ifdef MISR_EN
      misr        <= 16'h0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            truth_table <= 64'h0;
            ones        <= 7'd0;
            pass        <= 1'b0;
`ifdef MISR_EN
            misr        <= 16'hFFFF;
`endif
            vec         <= 6'd0;
            counter_reg <= 4'd0;
            busy        <= 1'b1;
            state_reg   <= RUN;
          end
        end
        RUN: begin
          // x is sampled on the last edge of each vector's SETTLE+1 cycle hold
          if (counter_reg == SETTLE_CNT) begin
            truth_table[vec] <= x;
            ones             <= ones + {6'd0, x};
`ifdef MISR_EN
            misr             <= {misr[14:0], 1'b0} ^ (misr_fb ? 16'h1021 : 16'h0000);
`endif
            counter_reg      <= 4'd0;
            if (vec == 6'd63) state_reg <= FINISH;
            else              vec       <= vec + 6'd1;
          end else begin
            counter_reg <= counter_reg + 4'd1;
          end
        end
        FINISH: begin
          busy      <= 1'b0;
          done      <= 1'b1;
          pass      <= (truth_table == EXPECTED);
          vec       <= 6'd0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
